lsu_dccm_wr_arb: RTL and testbench

//  Arbitrates the single DCCM write port among three requesters:
//  - ECC correction writeback, DMA write, store-buffer drain.
//  A DC1 load read blocks writes to the banks it is reading (bank conflict).

---
 rtl/lsu_dccm_wr_arb_if.sv | 46 ++++
 rtl/lsu_dccm_wr_arb.sv | 121 ++++++++++++
 tb/tb_lsu_dccm_wr_arb.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lsu_dccm_wr_arb_if.sv
// DCCM write-port arbitration bus: requester side, load-bank
// snoop from DC1, and the granted DCCM write.
interface lsu_dccm_wr_arb_if #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int DCCM_BANK_BITS   = 3
);
  logic                        lsu_freeze_dc3;
  logic                        ld_rden_dc1;
  logic [DCCM_BANK_BITS-1:0]   ld_lo_bank_dc1;
  logic [DCCM_BANK_BITS-1:0]   ld_hi_bank_dc1;
  logic                        ecc_wb_req;
  logic [DCCM_BITS-1:0]        ecc_wb_addr;
  logic [DCCM_FDATA_WIDTH-1:0] ecc_wb_data;
  logic                        ecc_wb_gnt;
  logic                        dma_wr_req;
  logic [DCCM_BITS-1:0]        dma_wr_addr;
  logic [DCCM_FDATA_WIDTH-1:0] dma_wr_data;
  logic                        dma_wr_gnt;
  logic                        stbuf_req;
  logic [DCCM_BITS-1:0]        stbuf_addr;
  logic [DCCM_FDATA_WIDTH-1:0] stbuf_data;
  logic                        stbuf_gnt;
  logic                        ld_stall_req;
  logic                        dccm_wren;
  logic [DCCM_BITS-1:0]        dccm_wr_addr;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data;

  modport master (
    output lsu_freeze_dc3, ld_rden_dc1, ld_lo_bank_dc1, ld_hi_bank_dc1,
           ecc_wb_req, ecc_wb_addr, ecc_wb_data,
           dma_wr_req, dma_wr_addr, dma_wr_data,
           stbuf_req, stbuf_addr, stbuf_data,
    input  ecc_wb_gnt, dma_wr_gnt, stbuf_gnt, ld_stall_req,
           dccm_wren, dccm_wr_addr, dccm_wr_data
  );

  modport slave (
    input  lsu_freeze_dc3, ld_rden_dc1, ld_lo_bank_dc1, ld_hi_bank_dc1,
           ecc_wb_req, ecc_wb_addr, ecc_wb_data,
           dma_wr_req, dma_wr_addr, dma_wr_data,
           stbuf_req, stbuf_addr, stbuf_data,
    output ecc_wb_gnt, dma_wr_gnt, stbuf_gnt, ld_stall_req,
           dccm_wren, dccm_wr_addr, dccm_wr_data
  );
endinterface

// File: rtl/lsu_dccm_wr_arb.sv
// DCCM write-port arbiter: ECC writeback, DMA write and store-buffer
// drain share one write port. Writes to banks a DC1 load is reading are
// held off, and a starvation FSM protects the store buffer by stalling loads.

// Per-requester bank-conflict check against the DC1 load.
module lsu_dccm_wr_arb_bank_chk #(
  parameter int DCCM_BANK_BITS = 3
) (
  input  logic [DCCM_BANK_BITS-1:0] i_bank,
  input  logic                      i_rden,
  input  logic [DCCM_BANK_BITS-1:0] i_lo,
  input  logic [DCCM_BANK_BITS-1:0] i_hi,
  output logic                      o_blk
);
  assign o_blk = i_rden & ((i_bank == i_lo) | (i_bank == i_hi));
endmodule

module lsu_dccm_wr_arb #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int DCCM_BANK_BITS   = 3,
  parameter int DCCM_WIDTH_BITS  = 2,
  parameter int STARVE_MAX       = 15
) (
  input  logic              clk,
  input  logic              rst_l,
  lsu_dccm_wr_arb_if.slave  bus
);
  localparam int NUM_REQ = 3;
  localparam int ECC = 0;
  localparam int DMA = 1;
  localparam int STB = 2;
  localparam logic [7:0] L_MAX = 8'(STARVE_MAX);

  typedef enum logic {NORMAL, STARVED} state_t;

  logic [NUM_REQ-1:0][DCCM_BITS-1:0]        w_addr;
  logic [NUM_REQ-1:0][DCCM_FDATA_WIDTH-1:0] w_data;
  logic [NUM_REQ-1:0] w_req, w_blk, w_elig, w_gnt;
  logic [DCCM_BITS-1:0]        w_wr_addr;
  logic [DCCM_FDATA_WIDTH-1:0] w_wr_data;
  logic [7:0] r_scnt, w_scnt_nxt;
  logic       r_rr_last;
  state_t     r_state, w_state_nxt;

  assign w_req  = {bus.stbuf_req,  bus.dma_wr_req,  bus.ecc_wb_req};
  assign w_addr = {bus.stbuf_addr, bus.dma_wr_addr, bus.ecc_wb_addr};
  assign w_data = {bus.stbuf_data, bus.dma_wr_data, bus.ecc_wb_data};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    lsu_dccm_wr_arb_bank_chk #(.DCCM_BANK_BITS(DCCM_BANK_BITS)) u_chk (
      .i_bank (w_addr[g][DCCM_WIDTH_BITS +: DCCM_BANK_BITS]),
      .i_rden (bus.ld_rden_dc1),
      .i_lo   (bus.ld_lo_bank_dc1),
      .i_hi   (bus.ld_hi_bank_dc1),
      .o_blk  (w_blk[g])
    );
  end

  // Nothing may win while frozen or while reset is held.
  assign w_elig = w_req & ~w_blk & {NUM_REQ{~bus.lsu_freeze_dc3 & rst_l}};

  // Grant selection, write mux, starvation counter and next state.
  always_comb begin
    w_gnt       = '0;
    w_wr_addr   = '0;
    w_wr_data   = '0;
    w_scnt_nxt  = r_scnt;
    w_state_nxt = r_state;

    if (r_state == STARVED && w_elig[STB]) w_gnt[STB] = 1'b1;
    else if (w_elig[ECC])                  w_gnt[ECC] = 1'b1;
    else if (w_elig[DMA] && w_elig[STB])   w_gnt[r_rr_last ? DMA : STB] = 1'b1;
    else if (w_elig[DMA])                  w_gnt[DMA] = 1'b1;
    else if (w_elig[STB])                  w_gnt[STB] = 1'b1;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_wr_addr = w_addr[i];
        w_wr_data = w_data[i];
      end
    end

    // Clear takes precedence over the freeze hold.
    if (!bus.stbuf_req || w_gnt[STB])  w_scnt_nxt = '0;
    else if (bus.lsu_freeze_dc3)       w_scnt_nxt = r_scnt;
    else if (r_scnt != L_MAX)          w_scnt_nxt = r_scnt + 8'd1;

    // Enter starvation on the edge the count reaches its limit.
    case (r_state)
      NORMAL:  if (bus.stbuf_req && !w_gnt[STB] && !bus.lsu_freeze_dc3 &&
                   w_scnt_nxt == L_MAX)
                 w_state_nxt = STARVED;
      STARVED: if (!bus.lsu_freeze_dc3 && (w_gnt[STB] || !bus.stbuf_req))
                 w_state_nxt = NORMAL;
      default: w_state_nxt = NORMAL;
    endcase
  end

  // State, starvation count and DMA/stbuf round-robin pointer.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state   <= NORMAL;
      r_scnt    <= '0;
      r_rr_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_scnt  <= w_scnt_nxt;
      if (w_gnt[STB])      r_rr_last <= 1'b1;
      else if (w_gnt[DMA]) r_rr_last <= 1'b0;
    end
  end

  assign bus.ecc_wb_gnt   = w_gnt[ECC];
  assign bus.dma_wr_gnt   = w_gnt[DMA];
  assign bus.stbuf_gnt    = w_gnt[STB];
  assign bus.dccm_wren    = |w_gnt;
  assign bus.dccm_wr_addr = w_wr_addr;
  assign bus.dccm_wr_data = w_wr_data;
  assign bus.ld_stall_req = (r_state == STARVED);
endmodule

// File: tb/tb_lsu_dccm_wr_arb.sv
// Directed bench for lsu_dccm_wr_arb: expected port values are queued as
// each step is driven and popped/compared away from the clock edge.
module tb_lsu_dccm_wr_arb;
  localparam int BITS = 16;
  localparam int FW   = 39;
  localparam int BB   = 3;

  localparam logic [BITS-1:0] ECC_A = 16'h0000;  // bank 0
  localparam logic [BITS-1:0] DMA_A = 16'h0004;  // bank 1
  localparam logic [BITS-1:0] STB_A = 16'h0010;  // bank 4
  localparam logic [FW-1:0]   ECC_D = 39'h11_2233_4455;
  localparam logic [FW-1:0]   DMA_D = 39'h22_6677_8899;
  localparam logic [FW-1:0]   STB_D = 39'h33_AABB_CCDD;

  typedef struct packed {
    logic [2:0]      gnt;   // {stbuf, dma, ecc}
    logic            wren;
    logic [BITS-1:0] addr;
    logic [FW-1:0]   data;
    logic            stall;
  } obs_t;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  lsu_dccm_wr_arb_if #(.DCCM_BITS(BITS), .DCCM_FDATA_WIDTH(FW), .DCCM_BANK_BITS(BB)) bus ();

  lsu_dccm_wr_arb #(
    .DCCM_BITS(BITS), .DCCM_FDATA_WIDTH(FW), .DCCM_BANK_BITS(BB),
    .DCCM_WIDTH_BITS(2), .STARVE_MAX(3)
  ) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic obs_t model(input logic [2:0] g, input logic s);
    obs_t o;
    o.gnt = g; o.wren = |g; o.stall = s;
    case (g)
      3'b001:  begin o.addr = ECC_A; o.data = ECC_D; end
      3'b010:  begin o.addr = DMA_A; o.data = DMA_D; end
      3'b100:  begin o.addr = STB_A; o.data = STB_D; end
      default: begin o.addr = '0;    o.data = '0;    end
    endcase
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.gnt   = {bus.stbuf_gnt, bus.dma_wr_gnt, bus.ecc_wb_gnt};
    o.wren  = bus.dccm_wren;
    o.addr  = bus.dccm_wr_addr;
    o.data  = bus.dccm_wr_data;
    o.stall = bus.ld_stall_req;
    return o;
  endfunction

  task automatic pop_cmp(input string tag);
    obs_t e, a;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      a = sample();
      assert (a === e) else begin
        n_bad++;
        $error("FAIL %s: got gnt=%b wren=%b addr=%h data=%h stall=%b want gnt=%b wren=%b addr=%h data=%h stall=%b",
               tag, a.gnt, a.wren, a.addr, a.data, a.stall, e.gnt, e.wren, e.addr, e.data, e.stall);
      end
    end
  endtask

  task automatic chk_now(input string tag, input logic [2:0] g, input logic s);
    sb.push_back(model(g, s));
    #1;
    pop_cmp(tag);
  endtask

  task automatic chk(input string tag, input logic [2:0] g, input logic s);
    sb.push_back(model(g, s));
    @(negedge clk);
    pop_cmp(tag);
  endtask

  task automatic chk_scnt(input string tag, input logic [7:0] exp);
    n_cmp++;
    assert (dut.r_scnt === exp) else begin
      n_bad++;
      $error("FAIL %s: scnt got %0d want %0d", tag, dut.r_scnt, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic reqs(input logic e, input logic d, input logic s);
    bus.ecc_wb_req = e; bus.dma_wr_req = d; bus.stbuf_req = s;
  endtask

  task automatic ld(input logic rd, input logic [BB-1:0] lo, input logic [BB-1:0] hi);
    bus.ld_rden_dc1 = rd; bus.ld_lo_bank_dc1 = lo; bus.ld_hi_bank_dc1 = hi;
  endtask

  initial begin
    bus.lsu_freeze_dc3 = 1'b0;
    bus.ecc_wb_addr = ECC_A; bus.ecc_wb_data = ECC_D;
    bus.dma_wr_addr = DMA_A; bus.dma_wr_data = DMA_D;
    bus.stbuf_addr  = STB_A; bus.stbuf_data  = STB_D;
    reqs(1, 1, 1);
    ld(0, 3'd0, 3'd0);

    // Reset held with every requester active.
    #2;
    chk_now("reset_all_req", 3'b000, 1'b0);
    chk_scnt("reset_scnt", 8'd0);

    // Release: ECC wins the first cycle.
    nxt(); rst_l = 1'b1;
    chk("rel_ecc_first", 3'b001, 0);

    // DMA and stbuf alternate, stbuf first.
    nxt(); reqs(0, 1, 1); chk("rr_stb0", 3'b100, 0);
    nxt(); chk("rr_dma0", 3'b010, 0);
    nxt(); chk("rr_stb1", 3'b100, 0);
    nxt(); chk("rr_dma1", 3'b010, 0);

    // Bank conflict on the load's low bank, then cleared.
    nxt(); reqs(0, 0, 1); ld(1, 3'd4, 3'd4); chk("blk_lo", 3'b000, 0);
    nxt(); ld(0, 3'd4, 3'd4); chk("unblk_stb", 3'b100, 0);

    // Blocked via the high bank for three cycles -> starvation.
    nxt(); ld(1, 3'd1, 3'd4); chk("starve_c1", 3'b000, 0);
    nxt(); chk("starve_c2", 3'b000, 0);
    nxt(); chk("starve_c3", 3'b000, 0);
    nxt(); chk("starve_stall", 3'b000, 1); chk_scnt("starve_scnt_sat", 8'd3);
    nxt(); chk("starve_hold", 3'b000, 1); chk_scnt("starve_scnt_sat2", 8'd3);
    nxt(); ld(0, 3'd0, 3'd0); reqs(1, 0, 1); chk("starve_stb_over_ecc", 3'b100, 1);
    nxt(); reqs(1, 0, 0); chk("starve_exit_ecc", 3'b001, 0);

    // Freeze holds the count and blocks every grant.
    nxt(); reqs(0, 0, 1); ld(1, 3'd4, 3'd4); chk("pre_frz", 3'b000, 0);
    nxt(); bus.lsu_freeze_dc3 = 1'b1; reqs(1, 1, 1); chk("frz_c1", 3'b000, 0);
    chk_scnt("frz_scnt1", 8'd1);
    nxt(); chk("frz_c2", 3'b000, 0); chk_scnt("frz_scnt2", 8'd1);
    nxt(); bus.lsu_freeze_dc3 = 1'b0; ld(0, 3'd0, 3'd0); chk("unfrz_ecc", 3'b001, 0);
    nxt(); reqs(0, 1, 1); chk("unfrz_rr_dma", 3'b010, 0);
    nxt(); chk("starve2_stb", 3'b100, 1);
    nxt(); reqs(0, 1, 0); chk("starve2_exit_dma", 3'b010, 0);

    // Enter starvation again, then async reset mid-cycle.
    nxt(); reqs(0, 0, 1); ld(1, 3'd4, 3'd4); chk("rst_pre1", 3'b000, 0);
    nxt(); chk("rst_pre2", 3'b000, 0);
    nxt(); chk("rst_pre3", 3'b000, 0);
    nxt(); chk("rst_starved", 3'b000, 1);
    #2; rst_l = 1'b0;
    chk_now("async_rst_stall", 3'b000, 0);
    chk_scnt("async_rst_scnt", 8'd0);
    nxt(); rst_l = 1'b1; ld(0, 3'd0, 3'd0); reqs(1, 0, 1);
    chk("post_rst_normal_ecc", 3'b001, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
